// File: rtl/period_meter.sv
// Period / high-time meter for an asynchronous input, counted in iCE ticks, with saturation.
// Optional 4-sample running average on oAvg when PERIOD_AVG_EN is defined.
module period_meter #(
    parameter int unsigned WIDTH       = 14,
    parameter int unsigned MAX_COUNT   = 10000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iCE,
    input  logic             iSignal,
    input  logic             iMode,
    output logic [WIDTH-1:0] oCycles,
    output logic             oValid,
    output logic             oTimeout
`ifdef PERIOD_AVG_EN
    ,
    output logic [WIDTH-1:0] oAvg
`endif
);

    typedef enum logic [0:0] {StArm, StRun} state_t;

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_COUNT);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_mode;
    logic [WIDTH-1:0]       r_count;
    logic [WIDTH-1:0]       r_cycles;
    logic                   r_valid;
    logic                   r_timeout;

    logic             w_sync_out;
    logic             w_rise;
    logic             w_fall;
    logic             w_term;
    logic             w_mode_chg;
    logic [WIDTH-1:0] w_next;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_hist;
    assign w_fall     = ~w_sync_out & r_hist;
    assign w_term     = r_mode ? w_fall : w_rise;
    assign w_mode_chg = iMode ^ r_mode;
    assign w_next     = r_count + WIDTH'(1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= StArm;
            r_sync    <= '0;
            r_hist    <= 1'b0;
            r_mode    <= 1'b0;
            r_count   <= '0;
            r_cycles  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (iCE) begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], iSignal};
                r_hist <= w_sync_out;
                r_mode <= iMode;
                case (r_state)
                    StArm: begin
                        if (w_rise) begin
                            r_count <= '0;
                            r_state <= StRun;
                        end
                    end
                    StRun: begin
                        // A mode switch invalidates the running count; drop it silently.
                        if (w_mode_chg) begin
                            r_state <= StArm;
                        end else if (w_term) begin
                            r_cycles  <= w_next;
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b0;
                            r_count   <= '0;
                            if (r_mode) begin
                                r_state <= StArm;
                            end
                        end else if (w_next == LP_MAX) begin
                            r_cycles  <= LP_MAX;
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b1;
                            r_state   <= StArm;
                        end else begin
                            r_count <= w_next;
                        end
                    end
                    default: r_state <= StArm;
                endcase
            end
        end
    end

    assign oCycles  = r_cycles;
    assign oValid   = r_valid;
    assign oTimeout = r_timeout;

`ifdef PERIOD_AVG_EN
    // r_cycles holds the newest sample; r_s0..r_s2 are the three before it.
    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_avg;
    logic [WIDTH+1:0] w_sum;

    assign w_sum = {2'b00, r_cycles} + {2'b00, r_s0} + {2'b00, r_s1} + {2'b00, r_s2};

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_s0  <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
            r_avg <= '0;
        end else if (iCE && w_mode_chg) begin
            r_s0  <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
            r_avg <= '0;
        end else if (r_valid) begin
            r_s0  <= r_cycles;
            r_s1  <= r_s0;
            r_s2  <= r_s1;
            r_avg <= w_sum[WIDTH+1:2];
        end
    end

    assign oAvg = r_avg;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: directed waveforms push expected results,
// a negedge monitor pops and compares on every oValid strobe.
module tb_period_meter;

    localparam int W = 14;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iCE;
    logic         iSignal;
    logic         iMode;
    logic [W-1:0] oCycles;
    logic         oValid;
    logic         oTimeout;
`ifdef PERIOD_AVG_EN
    logic [W-1:0] oAvg;
`endif

    period_meter #(
        .WIDTH       (W),
        .MAX_COUNT   (10000),
        .SYNC_STAGES (2)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iCE      (iCE),
        .iSignal  (iSignal),
        .iMode    (iMode),
        .oCycles  (oCycles),
        .oValid   (oValid),
        .oTimeout (oTimeout)
`ifdef PERIOD_AVG_EN
        ,
        .oAvg     (oAvg)
`endif
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [W-1:0] cyc;
        logic         to;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc_cnt = 0;
    bit   ce_half = 1'b0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int c, input bit to);
        exp_t e;
        e.cyc = W'(c);
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
        cyc_cnt++;
    endtask

    task automatic drive(input logic sig, input int n);
        for (int i = 0; i < n; i++) begin
            iSignal = sig;
            iCE     = ce_half ? logic'(cyc_cnt % 2 == 0) : 1'b1;
            step();
        end
    endtask

    // Reset is applied with iCE low to show it does not depend on the tick enable.
    task automatic do_reset(input string tag);
        iRst    = 1'b1;
        iSignal = 1'b0;
        iCE     = 1'b0;
        step();
        step();
        iRst = 1'b0;
        check({tag, "_rst_cycles"}, int'(oCycles), 0);
        check({tag, "_rst_valid"}, int'(oValid), 0);
        check({tag, "_rst_timeout"}, int'(oTimeout), 0);
`ifdef PERIOD_AVG_EN
        check({tag, "_rst_avg"}, int'(oAvg), 0);
`endif
    endtask

    always @(negedge iClk) begin
        if (oValid) begin
            exp_t e;
            check("valid_single_cycle", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", int'(oCycles), -1);
            end else begin
                e = exp_q.pop_front();
                check("result_cycles", int'(oCycles), int'(e.cyc));
                check("result_timeout", int'(oTimeout), int'(e.to));
            end
        end
        prev_valid <= oValid;
    end

    initial begin
        iRst    = 1'b1;
        iCE     = 1'b0;
        iSignal = 1'b0;
        iMode   = 1'b0;
        step();
        do_reset("init");

        // Period mode, 100-clock square wave: 4 rising edges -> 3 results.
        push(100, 0); push(100, 0); push(100, 0);
        for (int p = 0; p < 4; p++) begin
            drive(1'b1, 50);
            drive(1'b0, 50);
        end
        drive(1'b0, 10);
        do_reset("period");

        // High-time mode, 30 high of 100.
        iMode = 1'b1;
        do_reset("hmode");
        push(30, 0); push(30, 0); push(30, 0);
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 30);
            drive(1'b0, 70);
        end
        iMode = 1'b0;
        do_reset("high");

        // One rising edge then silence: saturate, then re-arm on the next edges.
        push(10000, 1);
        drive(1'b1, 5);
        drive(1'b0, 10020);
        check("timeout_sticky", int'(oTimeout), 1);
        check("timeout_cycles_hold", int'(oCycles), 10000);
        push(100, 0);
        drive(1'b1, 50);
        drive(1'b0, 50);
        drive(1'b1, 50);
        drive(1'b0, 10);
        check("timeout_cleared", int'(oTimeout), 0);
        do_reset("timeout");

        // Tick enable every other clock: 100 clocks = 50 ticks.
        ce_half = 1'b1;
        push(50, 0); push(50, 0);
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 50);
            drive(1'b0, 50);
        end
        drive(1'b0, 10);
        ce_half = 1'b0;
        do_reset("cehalf");

        // Reset 40 clocks into a measurement, then a clean result.
        push(100, 0); push(100, 0);
        drive(1'b1, 50); drive(1'b0, 50);
        drive(1'b1, 50); drive(1'b0, 50);
        drive(1'b1, 40);
        do_reset("midrst");
        push(100, 0);
        drive(1'b1, 50); drive(1'b0, 50);
        drive(1'b1, 50); drive(1'b0, 10);
        do_reset("rearm");

        // Mode toggle mid-RUN aborts silently; next high time measured in new mode.
        push(100, 0); push(50, 0);
        drive(1'b1, 50); drive(1'b0, 50);
        drive(1'b1, 40);
        iMode = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 5);
        check("mode_abort_hold", int'(oCycles), 100);
        drive(1'b0, 45);
        drive(1'b1, 50);
        drive(1'b0, 60);
        iMode = 1'b0;
        do_reset("modechg");

`ifdef PERIOD_AVG_EN
        // Periods 100,200,300,400 -> average 250.
        push(100, 0); push(200, 0); push(300, 0); push(400, 0);
        drive(1'b1, 50);  drive(1'b0, 50);
        drive(1'b1, 100); drive(1'b0, 100);
        drive(1'b1, 150); drive(1'b0, 150);
        drive(1'b1, 200); drive(1'b0, 200);
        drive(1'b1, 5);
        drive(1'b0, 10);
        check("avg_value", int'(oAvg), 250);
        do_reset("avg");
`endif

        drive(1'b0, 5);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
